mac_wave_seq_ctrl: RTL and testbench

//  Sequencer for one bit-serial 16-lane MAC unit: accepts a job descriptor, primes and clears the MAC,

---
 rtl/mac_wave_seq_ctrl.sv | 180 ++++++++++++++++++
 tb/tb_mac_wave_seq_ctrl.sv | 350 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mac_wave_seq_ctrl.sv
// Sequencer for a bit-serial 16-lane MAC: prime, clear, column/tile issue with stall, drain, result hold.
// Optional performance counters (perf_jobs, perf_stalls) are built when MAC_SEQ_PERF_CNT_EN is defined.
module mac_wave_seq_ctrl #(
  parameter int TILE_W = 8,
  parameter int PERF_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              job_valid,
  output logic              job_ready,
  input  logic [2:0]        job_ncols,
  input  logic [TILE_W-1:0] job_ntiles,
  input  logic              job_load_prev,
  input  logic              job_pool,
  input  logic              act_valid,
  output logic              act_ready,
  output logic              mac_reset,
  output logic              mac_en,
  output logic              mac_load_accum,
  output logic              mac_is_pooling,
  output logic [2:0]        mac_column_idx,
  output logic              bit_gate,
  output logic [TILE_W-1:0] tile_idx,
  output logic              res_valid,
  input  logic              res_ready,
  output logic              busy
`ifdef MAC_SEQ_PERF_CNT_EN
  ,
  output logic [PERF_W-1:0] perf_jobs,
  output logic [PERF_W-1:0] perf_stalls
`endif
);

  if (TILE_W < 1 || PERF_W < 1) begin : g_param_check
    $error("mac_wave_seq_ctrl: TILE_W and PERF_W must be positive");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_PRIME,
    S_CLR,
    S_ISSUE,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t            state;
  logic [2:0]        ncols_m1;
  logic [TILE_W-1:0] tile_last;
  logic              load_prev;
  logic              first_pending;
  logic [2:0]        col;
  logic [TILE_W-1:0] tile;
  logic              job_ready_r;
  logic              busy_r;
  logic              pool_r;
  logic              bit_gate_r;
  logic              res_valid_r;
  logic              pump_r;   // PRIME/DRAIN: clock the pipe register with a zero psum
  logic              clr_r;
  logic              issue_fire;

  assign issue_fire = (state == S_ISSUE) && act_valid && !reset;

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= S_IDLE;
      job_ready_r   <= 1'b1;
      busy_r        <= 1'b0;
      pool_r        <= 1'b0;
      bit_gate_r    <= 1'b0;
      res_valid_r   <= 1'b0;
      pump_r        <= 1'b0;
      clr_r         <= 1'b0;
      col           <= '0;
      tile          <= '0;
      ncols_m1      <= '0;
      tile_last     <= '0;
      load_prev     <= 1'b0;
      first_pending <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (job_valid) begin
            state         <= S_PRIME;
            job_ready_r   <= 1'b0;
            busy_r        <= 1'b1;
            pool_r        <= job_pool;
            pump_r        <= 1'b1;
            ncols_m1      <= (job_ncols == 3'd0) ? 3'd0 : job_ncols - 3'd1;
            tile_last     <= (job_ntiles == '0) ? '0 : job_ntiles - 1'b1;
            load_prev     <= job_load_prev;
            first_pending <= 1'b1;
          end
        end
        S_PRIME: begin
          state  <= S_CLR;
          pump_r <= 1'b0;
          clr_r  <= 1'b1;
        end
        S_CLR: begin
          state      <= S_ISSUE;
          clr_r      <= 1'b0;
          bit_gate_r <= 1'b1;
          col        <= ncols_m1;
          tile       <= '0;
        end
        S_ISSUE: begin
          // Stalled cycles change nothing, so first_pending survives until the first real issue.
          if (act_valid) begin
            first_pending <= 1'b0;
            if (col != 3'd0) begin
              col <= col - 3'd1;
            end else if (tile != tile_last) begin
              tile <= tile + 1'b1;
              col  <= ncols_m1;
            end else begin
              state      <= S_DRAIN;
              bit_gate_r <= 1'b0;
              pump_r     <= 1'b1;
            end
          end
        end
        S_DRAIN: begin
          state       <= S_DONE;
          pump_r      <= 1'b0;
          res_valid_r <= 1'b1;
        end
        S_DONE: begin
          if (res_ready) begin
            state       <= S_IDLE;
            res_valid_r <= 1'b0;
            busy_r      <= 1'b0;
            job_ready_r <= 1'b1;
            pool_r      <= 1'b0;
            col         <= '0;
            tile        <= '0;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Enable-type outputs are forced off while reset is asserted so an abandoned job consumes nothing.
  assign mac_en         = !reset && (pump_r || ((state == S_ISSUE) && act_valid));
  assign act_ready      = issue_fire;
  assign mac_reset      = reset || clr_r;
  assign mac_load_accum = issue_fire && first_pending && load_prev;
  assign mac_is_pooling = pool_r;
  assign mac_column_idx = col;
  assign bit_gate       = bit_gate_r;
  assign tile_idx       = tile;
  assign res_valid      = res_valid_r;
  assign job_ready      = job_ready_r;
  assign busy           = busy_r;

`ifdef MAC_SEQ_PERF_CNT_EN
  logic [PERF_W-1:0] jobs_cnt;
  logic [PERF_W-1:0] stalls_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      jobs_cnt   <= '0;
      stalls_cnt <= '0;
    end else begin
      if ((state == S_DONE) && res_ready && (jobs_cnt != '1)) begin
        jobs_cnt <= jobs_cnt + 1'b1;
      end
      if ((state == S_ISSUE) && !act_valid && (stalls_cnt != '1)) begin
        stalls_cnt <= stalls_cnt + 1'b1;
      end
    end
  end

  assign perf_jobs   = jobs_cnt;
  assign perf_stalls = stalls_cnt;
`endif

endmodule

// File: tb/tb_mac_wave_seq_ctrl.sv
// Scoreboard bench for mac_wave_seq_ctrl: the driver predicts per-cycle outputs from job arithmetic,
// a negedge monitor pops and compares. Define MAC_SEQ_PERF_CNT_EN to also check the counters.
module tb_mac_wave_seq_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       job_valid;
  logic       job_ready;
  logic [2:0] job_ncols;
  logic [7:0] job_ntiles;
  logic       job_load_prev;
  logic       job_pool;
  logic       act_valid;
  logic       act_ready;
  logic       mac_reset;
  logic       mac_en;
  logic       mac_load_accum;
  logic       mac_is_pooling;
  logic [2:0] mac_column_idx;
  logic       bit_gate;
  logic [7:0] tile_idx;
  logic       res_valid;
  logic       res_ready;
  logic       busy;
`ifdef MAC_SEQ_PERF_CNT_EN
  logic [31:0] perf_jobs;
  logic [31:0] perf_stalls;
  logic [31:0] exp_pj;
  logic [31:0] exp_ps;
`endif

  always #5 clk = ~clk;

  mac_wave_seq_ctrl #(.TILE_W(8), .PERF_W(32)) dut (
    .clk(clk), .reset(reset),
    .job_valid(job_valid), .job_ready(job_ready),
    .job_ncols(job_ncols), .job_ntiles(job_ntiles),
    .job_load_prev(job_load_prev), .job_pool(job_pool),
    .act_valid(act_valid), .act_ready(act_ready),
    .mac_reset(mac_reset), .mac_en(mac_en), .mac_load_accum(mac_load_accum),
    .mac_is_pooling(mac_is_pooling), .mac_column_idx(mac_column_idx),
    .bit_gate(bit_gate), .tile_idx(tile_idx),
    .res_valid(res_valid), .res_ready(res_ready), .busy(busy)
`ifdef MAC_SEQ_PERF_CNT_EN
    , .perf_jobs(perf_jobs), .perf_stalls(perf_stalls)
`endif
  );

  typedef struct packed {
    logic       job_ready;
    logic       busy;
    logic       mac_reset;
    logic       mac_en;
    logic       act_ready;
    logic       load_accum;
    logic       pooling;
    logic       bit_gate;
    logic       res_valid;
    logic [2:0] col;
    logic [7:0] tile;
`ifdef MAC_SEQ_PERF_CNT_EN
    logic [31:0] pjobs;
    logic [31:0] pstalls;
`endif
  } obs_t;

  obs_t  exp_q[$];
  obs_t  mask_q[$];
  string tag_q[$];
  int    n_tests = 0;
  int    n_fail  = 0;

  function automatic obs_t sample();
    obs_t a;
    a = '0;
    a.job_ready  = job_ready;
    a.busy       = busy;
    a.mac_reset  = mac_reset;
    a.mac_en     = mac_en;
    a.act_ready  = act_ready;
    a.load_accum = mac_load_accum;
    a.pooling    = mac_is_pooling;
    a.bit_gate   = bit_gate;
    a.res_valid  = res_valid;
    a.col        = mac_column_idx;
    a.tile       = tile_idx;
`ifdef MAC_SEQ_PERF_CNT_EN
    a.pjobs      = perf_jobs;
    a.pstalls    = perf_stalls;
`endif
    return a;
  endfunction

  // Monitor: one expectation per cycle, compared mid-cycle.
  initial begin
    obs_t  e;
    obs_t  m;
    obs_t  a;
    string t;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        m = mask_q.pop_front();
        t = tag_q.pop_front();
        a = sample();
        n_tests++;
        if (((a ^ e) & m) != '0) begin
          n_fail++;
          $display("FAIL %s: got %h expected %h (mask %h)", t, a, e, m);
        end else begin
          $display("[TB] ok %s: %h", t, a);
        end
      end
    end
  end

  function automatic obs_t with_perf(input obs_t e_in);
    obs_t e;
    e = e_in;
`ifdef MAC_SEQ_PERF_CNT_EN
    e.pjobs   = exp_pj;
    e.pstalls = exp_ps;
`endif
    return e;
  endfunction

  function automatic obs_t idle_exp();
    obs_t e;
    e = '0;
    e.job_ready = 1'b1;
    return with_perf(e);
  endfunction

  function automatic obs_t busy_exp(input bit pl);
    obs_t e;
    e = '0;
    e.busy    = 1'b1;
    e.pooling = pl;
    return with_perf(e);
  endfunction

  function automatic obs_t reset_mask();
    obs_t m;
    m = '0;
    m.mac_reset  = 1'b1;
    m.mac_en     = 1'b1;
    m.act_ready  = 1'b1;
    m.load_accum = 1'b1;
    return m;
  endfunction

  function automatic obs_t reset_exp();
    obs_t e;
    e = '0;
    e.mac_reset = 1'b1;
    return e;
  endfunction

  task automatic push(input obs_t e, input obs_t m, input string t);
    exp_q.push_back(e);
    mask_q.push_back(m);
    tag_q.push_back(t);
  endtask

  task automatic bump_stall();
`ifdef MAC_SEQ_PERF_CNT_EN
    exp_ps = exp_ps + 1;
`endif
  endtask

  task automatic bump_job();
`ifdef MAC_SEQ_PERF_CNT_EN
    exp_pj = exp_pj + 1;
`endif
  endtask

  task automatic clear_perf();
`ifdef MAC_SEQ_PERF_CNT_EN
    exp_pj = '0;
    exp_ps = '0;
`endif
  endtask

  // Random junk on inputs that must be ignored in the current state.
  task automatic noise();
    job_valid     = 1'($urandom);
    job_ncols     = 3'($urandom);
    job_ntiles    = 8'($urandom);
    job_load_prev = 1'($urandom);
    job_pool      = 1'($urandom);
    act_valid     = 1'($urandom);
    res_ready     = 1'($urandom);
  endtask

  task automatic idle_cycle();
    @(posedge clk); #1;
    noise();
    job_valid = 1'b0;
    push(idle_exp(), '1, "idle");
  endtask

  task automatic accept(input int nc_in, input int nt_in, input bit lp, input bit pl);
    @(posedge clk); #1;
    noise();
    job_valid     = 1'b1;
    job_ncols     = 3'(nc_in);
    job_ntiles    = 8'(nt_in);
    job_load_prev = lp;
    job_pool      = pl;
    push(idle_exp(), '1, "accept");
    @(posedge clk); #1;
    noise();
    begin
      obs_t e;
      e = busy_exp(pl);
      e.mac_en = 1'b1;
      push(e, '1, "prime");
      @(posedge clk); #1;
      noise();
      e = busy_exp(pl);
      e.mac_reset = 1'b1;
      push(e, '1, "clr");
    end
  endtask

  // One issue-phase cycle; returns whether the beat fired.
  task automatic issue_cycle(input int nc, input int k, input bit lp, input bit pl,
                             input bit av, input bit do_reset);
    obs_t e;
    @(posedge clk); #1;
    noise();
    act_valid = av;
    reset     = do_reset;
    if (do_reset) begin
      push(reset_exp(), reset_mask(), "reset_mid");
    end else begin
      e = busy_exp(pl);
      e.bit_gate   = 1'b1;
      e.col        = 3'(nc - 1 - (k % nc));
      e.tile       = 8'(k / nc);
      e.mac_en     = av;
      e.act_ready  = av;
      e.load_accum = av && lp && (k == 0);
      push(e, '1, av ? "issue" : "stall");
      if (!av) bump_stall();
    end
  endtask

  task automatic run_job(input int nc_in, input int nt_in, input bit lp, input bit pl,
                         input int stall_pct, input int forced, input int rr_wait);
    int   nc;
    int   nt;
    int   n;
    int   k;
    int   f;
    bit   av;
    obs_t e;
    nc = (nc_in == 0) ? 1 : nc_in;
    nt = (nt_in == 0) ? 1 : nt_in;
    n  = nc * nt;
    k  = 0;
    f  = forced;
    accept(nc_in, nt_in, lp, pl);
    while (k < n) begin
      if (k >= 1 && f > 0) begin
        av = 1'b0;
        f--;
      end else begin
        av = ($urandom_range(99) >= stall_pct);
      end
      issue_cycle(nc, k, lp, pl, av, 1'b0);
      if (av) k++;
    end
    @(posedge clk); #1;
    noise();
    e = busy_exp(pl);
    e.mac_en = 1'b1;
    e.tile   = 8'(nt - 1);
    push(e, '1, "drain");
    for (int i = 0; i <= rr_wait; i++) begin
      @(posedge clk); #1;
      noise();
      res_ready = (i == rr_wait);
      e = busy_exp(pl);
      e.res_valid = 1'b1;
      e.tile      = 8'(nt - 1);
      push(e, '1, "done");
    end
    bump_job();
    idle_cycle();
    $display("[TB] job ncols=%0d ntiles=%0d load_prev=%0d pool=%0d issues=%0d", nc_in, nt_in, lp, pl, n);
  endtask

  task automatic run_reset_mid();
    accept(2, 3, 1'b0, 1'b1);
    issue_cycle(2, 0, 1'b0, 1'b1, 1'b1, 1'b0);
    issue_cycle(2, 1, 1'b0, 1'b1, 1'b1, 1'b0);
    issue_cycle(2, 2, 1'b0, 1'b1, 1'b1, 1'b1);
    clear_perf();
    @(posedge clk); #1;
    reset = 1'b0;
    noise();
    job_valid = 1'b0;
    push(idle_exp(), '1, "after_reset");
    idle_cycle();
    $display("[TB] job reset mid-issue at tile 1");
  endtask

  initial begin
    reset         = 1'b1;
    job_valid     = 1'b0;
    job_ncols     = '0;
    job_ntiles    = '0;
    job_load_prev = 1'b0;
    job_pool      = 1'b0;
    act_valid     = 1'b0;
    res_ready     = 1'b0;
    clear_perf();
    @(posedge clk); #1;
    push(reset_exp(), reset_mask(), "in_reset");
    @(posedge clk); #1;
    reset = 1'b0;
    push(idle_exp(), '1, "reset_state");
    idle_cycle();

    run_job(4, 1, 1'b0, 1'b0, 0, 0, 0);
    run_job(2, 3, 1'b1, 1'b0, 0, 0, 1);
    run_job(3, 1, 1'b0, 1'b0, 0, 2, 0);
    run_job(4, 2, 1'b0, 1'b1, 0, 0, 5);
    run_reset_mid();
    run_job(0, 0, 1'b1, 1'b1, 0, 0, 0);
    run_job(3, 1, 1'b0, 1'b0, 0, 2, 0);
    for (int j = 0; j < 25; j++) begin
      run_job(int'($urandom_range(0, 7)), int'($urandom_range(0, 4)),
              1'($urandom), 1'($urandom), int'($urandom_range(0, 40)), 0,
              int'($urandom_range(0, 3)));
    end

    repeat (3) @(negedge clk);
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d pending expectations, required 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
